// File: rtl/card_allowlist_checker.sv
// Looks up a 128-bit card ID in an EEPROM-resident allow-list and reports grant/deny/error.
// ALLOWLIST_EARLY_EXIT_EN: skip the rest of an entry on its first mismatching byte (data-dependent timing).
module card_allowlist_checker #(
  parameter logic [6:0] BASE_ADDR      = 7'h20,
  parameter int         MAX_ENTRIES    = 4,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         chk_start,
  input  logic [127:0] card_id,
  output logic         chk_busy,
  output logic         chk_done,
  output logic         chk_grant,
  output logic [2:0]   chk_index,
  output logic         chk_error,
  output logic         eeprom_cmd_valid,
  input  logic         eeprom_cmd_ready,
  output logic [2:0]   eeprom_cmd_type,
  output logic [6:0]   eeprom_cmd_addr,
  output logic [7:0]   eeprom_cmd_wdata,
  input  logic [7:0]   eeprom_cmd_rdata,
  input  logic         eeprom_cmd_done,
  input  logic         eeprom_cmd_error,
  output logic [2:0]   dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  generate
    if (MAX_ENTRIES < 1 || MAX_ENTRIES > 7 ||
        int'(BASE_ADDR) + 1 + 16 * MAX_ENTRIES > 128) begin : g_bad_cfg
      $error("card_allowlist_checker: allow-list does not fit the EEPROM address space");
    end
  endgenerate

  // Handshake: a request is held while eeprom_cmd_valid=1 and is taken on the
  // first clk edge that samples eeprom_cmd_ready=1; exactly one read is in
  // flight until eeprom_cmd_done (with eeprom_cmd_error qualified by it).
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_REQ, S_CNT_WAIT, S_BYTE_REQ, S_BYTE_WAIT, S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [15:0][7:0]   card_q, card_d;
  logic [2:0]         entry_q, entry_d, last_q, last_d, index_q, index_d;
  logic [3:0]         byte_q, byte_d;
  logic               match_q, match_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               busy_q, busy_d, done_q, done_d, grant_q, grant_d;
  logic               error_q, error_d, valid_q, valid_d;
  logic [6:0]         addr_q, addr_d;
  logic               timeout, fail, flag;
  logic [2:0]         eff_cnt;
  logic [7:0]         id_byte;

  function automatic logic [6:0] addr_of(input logic [2:0] e, input logic [3:0] b);
    logic [7:0] sum;
    sum = 8'(BASE_ADDR) + 8'd1 + {1'b0, e, b};
    return sum[6:0];
  endfunction

  assign id_byte = card_q[4'd15 - byte_q];
  assign timeout = (state_q inside {S_CNT_REQ, S_CNT_WAIT, S_BYTE_REQ, S_BYTE_WAIT}) &&
                   (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign eff_cnt = (eeprom_cmd_rdata > 8'(MAX_ENTRIES)) ? 3'(MAX_ENTRIES) : eeprom_cmd_rdata[2:0];

  always_comb begin
    state_d = state_q;
    card_d  = card_q;
    entry_d = entry_q;
    byte_d  = byte_q;
    last_d  = last_q;
    match_d = match_q;
    timer_d = timer_q + TW'(1);
    busy_d  = busy_q;
    done_d  = 1'b0;
    grant_d = grant_q;
    index_d = index_q;
    error_d = error_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    fail    = 1'b0;
    flag    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start on the chk_done cycle is deliberately dropped.
        if (chk_start && !done_q) begin
          state_d = S_CNT_REQ;
          card_d  = card_id;
          grant_d = 1'b0;
          index_d = 3'd0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          addr_d  = BASE_ADDR;
          timer_d = '0;
          entry_d = 3'd0;
          byte_d  = 4'd0;
        end
      end
      S_CNT_REQ, S_BYTE_REQ: begin
        if (eeprom_cmd_ready) begin
          valid_d = 1'b0;
          state_d = (state_q == S_CNT_REQ) ? S_CNT_WAIT : S_BYTE_WAIT;
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      S_CNT_WAIT: begin
        if (eeprom_cmd_done) begin
          if (eeprom_cmd_error) begin
            fail = 1'b1;
          end else if (eff_cnt == 3'd0) begin
            state_d = S_FINISH;
          end else begin
            last_d  = eff_cnt - 3'd1;
            entry_d = 3'd0;
            byte_d  = 4'd0;
            valid_d = 1'b1;
            timer_d = '0;
            addr_d  = addr_of(3'd0, 4'd0);
            state_d = S_BYTE_REQ;
          end
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      S_BYTE_WAIT: begin
        if (eeprom_cmd_done) begin
          if (eeprom_cmd_error) begin
            fail = 1'b1;
          end else begin
            flag    = ((byte_q == 4'd0) ? 1'b1 : match_q) && (eeprom_cmd_rdata == id_byte);
            match_d = flag;
            state_d = S_BYTE_REQ;
`ifdef ALLOWLIST_EARLY_EXIT_EN
            if (byte_q == 4'd15 && flag) begin
              grant_d = 1'b1;
              index_d = entry_q;
              state_d = S_FINISH;
            end else if (byte_q == 4'd15 || !flag) begin
              if (entry_q == last_q) state_d = S_FINISH;
              else begin
                entry_d = entry_q + 3'd1;
                byte_d  = 4'd0;
              end
            end else begin
              byte_d = byte_q + 4'd1;
            end
`else
            // Every entry is read in full so latency never depends on the ID.
            if (byte_q == 4'd15) begin
              if (flag && !grant_q) begin
                grant_d = 1'b1;
                index_d = entry_q;
              end
              if (entry_q == last_q) state_d = S_FINISH;
              else begin
                entry_d = entry_q + 3'd1;
                byte_d  = 4'd0;
              end
            end else begin
              byte_d = byte_q + 4'd1;
            end
`endif
            if (state_d == S_BYTE_REQ) begin
              valid_d = 1'b1;
              timer_d = '0;
              addr_d  = addr_of(entry_d, byte_d);
            end
          end
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      error_d = 1'b1;
      grant_d = 1'b0;
      index_d = 3'd0;
      valid_d = 1'b0;
      state_d = S_FINISH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      card_q  <= '0;
      entry_q <= 3'd0;
      byte_q  <= 4'd0;
      last_q  <= 3'd0;
      match_q <= 1'b0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      grant_q <= 1'b0;
      index_q <= 3'd0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      card_q  <= card_d;
      entry_q <= entry_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      match_q <= match_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      index_q <= index_d;
      error_q <= error_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign chk_busy         = busy_q;
  assign chk_done         = done_q;
  assign chk_grant        = grant_q;
  assign chk_index        = index_q;
  assign chk_error        = error_q;
  assign eeprom_cmd_valid = valid_q;
  assign eeprom_cmd_addr  = addr_q;
  assign eeprom_cmd_type  = 3'b100;
  assign eeprom_cmd_wdata = 8'h00;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_card_allowlist_checker.sv
// Directed bench for card_allowlist_checker: EEPROM responder model plus a linear list of checks.
// Expected read counts follow ALLOWLIST_EARLY_EXIT_EN when it is defined.
module tb_card_allowlist_checker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         chk_start = 1'b0;
  logic [127:0] card_id = '0;
  logic         chk_busy, chk_done, chk_grant, chk_error;
  logic [2:0]   chk_index;
  logic         eeprom_cmd_valid;
  logic         eeprom_cmd_ready = 1'b0;
  logic [2:0]   eeprom_cmd_type;
  logic [6:0]   eeprom_cmd_addr;
  logic [7:0]   eeprom_cmd_wdata;
  logic [7:0]   eeprom_cmd_rdata = 8'h00;
  logic         eeprom_cmd_done = 1'b0;
  logic         eeprom_cmd_error = 1'b0;
  logic [2:0]   dbg_state;

  card_allowlist_checker dut (
    .clk(clk), .rst_n(rst_n), .chk_start(chk_start), .card_id(card_id),
    .chk_busy(chk_busy), .chk_done(chk_done), .chk_grant(chk_grant),
    .chk_index(chk_index), .chk_error(chk_error),
    .eeprom_cmd_valid(eeprom_cmd_valid), .eeprom_cmd_ready(eeprom_cmd_ready),
    .eeprom_cmd_type(eeprom_cmd_type), .eeprom_cmd_addr(eeprom_cmd_addr),
    .eeprom_cmd_wdata(eeprom_cmd_wdata), .eeprom_cmd_rdata(eeprom_cmd_rdata),
    .eeprom_cmd_done(eeprom_cmd_done), .eeprom_cmd_error(eeprom_cmd_error),
    .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  localparam logic [127:0] ID_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] ID_B = ~ID_A;
  localparam logic [127:0] ID_FILL = {16{8'hA5}};

  // ---- EEPROM responder model ----
  logic [7:0] mem [0:127];
  int         resp_delay = 5;
  int         err_on_read = 0;
  bit         ready_en = 1'b1;
  int         read_cnt = 0;
  logic [6:0] last_addr = '0;

  initial begin : eeprom_model
    logic [6:0] cur;
    forever begin
      @(negedge clk);
      eeprom_cmd_done  = 1'b0;
      eeprom_cmd_error = 1'b0;
      if (eeprom_cmd_valid && ready_en) begin
        eeprom_cmd_ready = 1'b1;
        read_cnt++;
        cur = eeprom_cmd_addr;
        last_addr = cur;
        @(negedge clk);
        eeprom_cmd_ready = 1'b0;
        repeat (resp_delay - 1) @(negedge clk);
        eeprom_cmd_rdata = mem[cur];
        eeprom_cmd_done  = 1'b1;
        eeprom_cmd_error = (read_cnt == err_on_read);
      end
    end
  end

  // ---- output monitor ----
  int cyc = 0, last_done_cyc = 0, done_gap = 0, done_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eeprom_cmd_done) last_done_cyc <= cyc;
    if (chk_done) begin
      done_cnt <= done_cnt + 1;
      done_gap <= cyc - last_done_cyc;
    end
  end

  // ---- scoreboard counters / compare ----
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---- driver tasks ----
  task automatic load_list(input logic [7:0] n, input logic [127:0] e0, input logic [127:0] e1,
                           input logic [127:0] e2, input logic [127:0] e3);
    logic [127:0] ents [4];
    ents[0] = e0; ents[1] = e1; ents[2] = e2; ents[3] = e3;
    for (int a = 0; a < 128; a++) mem[a] = 8'hFF;
    mem[7'h20] = n;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++)
        mem[7'h21 + 16 * i + k] = ents[i][127 - 8 * k -: 8];
  endtask

  task automatic start_check(input logic [127:0] id);
    @(negedge clk);
    read_cnt  = 0;
    card_id   = id;
    chk_start = 1'b1;
    @(negedge clk);
    chk_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!chk_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(chk_done), 32'd1);
  endtask

  // ---- directed sequence ----
  initial begin
    int hi;
    int saved;
    load_list(8'd2, ID_FILL, ID_A, ID_FILL, ID_FILL);
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(chk_busy), 32'd0);
    check("rst_done",  32'(chk_done), 32'd0);
    check("rst_grant", 32'(chk_grant), 32'd0);
    check("rst_index", 32'(chk_index), 32'd0);
    check("rst_error", 32'(chk_error), 32'd0);
    check("rst_valid", 32'(eeprom_cmd_valid), 32'd0);
    check("rst_addr",  32'(eeprom_cmd_addr), 32'd0);
    check("rst_type",  32'(eeprom_cmd_type), 32'd4);
    check("rst_wdata", 32'(eeprom_cmd_wdata), 32'd0);
    rst_n = 1'b1;

    // Grant on entry 1
    start_check(ID_A);
    check("c1_busy",  32'(chk_busy), 32'd1);
    check("c1_valid", 32'(eeprom_cmd_valid), 32'd1);
    check("c1_addr",  32'(eeprom_cmd_addr), 32'h20);
    wait_done("grant");
    check("grant_busy_low", 32'(chk_busy), 32'd0);
    check("grant_grant", 32'(chk_grant), 32'd1);
    check("grant_index", 32'(chk_index), 32'd1);
    check("grant_error", 32'(chk_error), 32'd0);
`ifdef ALLOWLIST_EARLY_EXIT_EN
    check("grant_reads", 32'(read_cnt), 32'd18);
`else
    check("grant_reads", 32'(read_cnt), 32'd33);
    check("grant_last_addr", 32'(last_addr), 32'h40);
`endif
    @(negedge clk);
    check("grant_done_gap", 32'(done_gap), 32'd2);
    check("grant_done_width", 32'(chk_done), 32'd0);

    // Empty list: one read then deny
    load_list(8'd0, ID_A, ID_A, ID_A, ID_A);
    start_check(ID_A);
    wait_done("empty");
    check("empty_reads", 32'(read_cnt), 32'd1);
    check("empty_addr",  32'(last_addr), 32'h20);
    check("empty_grant", 32'(chk_grant), 32'd0);
    check("empty_error", 32'(chk_error), 32'd0);

    // Count clamped to MAX_ENTRIES; entries differ only in the final byte
    load_list(8'd9, ID_A ^ 128'h1, ID_A ^ 128'h2, ID_A ^ 128'h3, ID_A ^ 128'h4);
    start_check(ID_A);
    wait_done("clamp");
    check("clamp_last_addr", 32'(last_addr), 32'h60);
    check("clamp_reads", 32'(read_cnt), 32'd65);
    check("clamp_grant", 32'(chk_grant), 32'd0);
    check("clamp_index", 32'(chk_index), 32'd0);

    // EEPROM error on 3rd read
    load_list(8'd2, ID_FILL, ID_A, ID_FILL, ID_FILL);
    err_on_read = 3;
    start_check(ID_A);
    wait_done("err");
    check("err_error", 32'(chk_error), 32'd1);
    check("err_grant", 32'(chk_grant), 32'd0);
    repeat (10) @(negedge clk);
    check("err_reads", 32'(read_cnt), 32'd3);
    check("err_valid_idle", 32'(eeprom_cmd_valid), 32'd0);
    err_on_read = 0;

    // Ready never comes: timeout after 4096 cycles of valid
    ready_en = 1'b0;
    start_check(ID_A);
    hi = 0;
    while (eeprom_cmd_valid && hi < 5000) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_valid_cycles", 32'(hi), 32'd4096);
    wait_done("tmo");
    check("tmo_error", 32'(chk_error), 32'd1);
    check("tmo_grant", 32'(chk_grant), 32'd0);

    // Reset mid-check forces reset values asynchronously, no chk_done
    start_check(ID_A);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(chk_busy), 32'd1);
    saved = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(chk_busy), 32'd0);
    check("arst_valid", 32'(eeprom_cmd_valid), 32'd0);
    check("arst_error", 32'(chk_error), 32'd0);
    check("arst_addr",  32'(eeprom_cmd_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'(saved));
    check("arst_idle_busy", 32'(chk_busy), 32'd0);

    // Starts while busy and on the chk_done cycle are ignored
    load_list(8'd2, ID_FILL, ID_A, ID_FILL, ID_FILL);
    start_check(ID_A);
    repeat (5) @(negedge clk);
    card_id = ID_B;
    chk_start = 1'b1;
    @(negedge clk);
    chk_start = 1'b0;
    wait_done("busy_start");
    check("busy_start_grant", 32'(chk_grant), 32'd1);
    check("busy_start_index", 32'(chk_index), 32'd1);
    saved = read_cnt;
    chk_start = 1'b1;
    @(negedge clk);
    chk_start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_start_busy", 32'(chk_busy), 32'd0);
    check("done_start_grant", 32'(chk_grant), 32'd1);
    check("done_start_reads", 32'(read_cnt), 32'(saved));

    // Next start one cycle later is accepted; ID_B is denied
    start_check(ID_B);
    wait_done("deny");
    check("deny_grant", 32'(chk_grant), 32'd0);
    check("deny_error", 32'(chk_error), 32'd0);

    // ---- final report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
